noc_router_param: RTL and testbench
===================================

# noc_router_param

Parametrised, credit-flow-controlled NoC router and next-generation successor of the fixed 5-port router. It has configurable port count, flit width, input-buffer depth and downstream credit depth. It uses a fixed 3-stage pipeline: input register, input FIFO with round-robin switch allocation, and registered crossbar output. Flits carry a pre-computed target port (lookahead routing) in their low bits. The block sits between network links and the local core/hub port.

## Interface
- NUM_PORTS, 5: number of input/output port pairs (2..8).
- DATA_W, 20: flit width in bits.
- FIFO_DEPTH, 4: per-input buffer depth; power of two, ≥2.
- CREDITS, 4: initial/maximum credit count per output; equals the downstream FIFO_DEPTH.
- TGT_W, 3: width of the target field, flit[TGT_W-1:0]; 2^TGT_W > NUM_PORTS.

- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  NUM_PORTS*DATA_W  input flits; port p occupies [p*DATA_W +: DATA_W].
- in_valid  in  NUM_PORTS  per-input flit valid.
- in_credit  in  NUM_PORTS  per-output credit return from downstream; 1-cycle pulse = 1 credit.
- out_data  out  NUM_PORTS*DATA_W  output flits, same packing as in_data.
- out_valid  out  NUM_PORTS  per-output flit valid.
- out_credit  out  NUM_PORTS  per-input credit return to upstream; 1-cycle pulse per flit consumed.
- ovf  out  NUM_PORTS  sticky: a flit arrived at a full input FIFO.
- bad_tgt  out  NUM_PORTS  sticky: an input head flit had an illegal target.

## Operation
- Stage 1: in_data/in_valid are registered unconditionally.
- Stage 2, push: a registered valid flit is written to its input FIFO.
  - If the FIFO is full, the flit is dropped and ovf[p] is set; occupancy is unchanged.
  - A push into a FIFO that is popping in the same cycle is legal when full.
- Target decode: head target t = flit[TGT_W-1:0].
  - For t in 1..NUM_PORTS, the request goes to output t-1.
  - For t=0 or t>NUM_PORTS, the head is discarded in that cycle: pop, out_credit pulse, bad_tgt[p] set, nothing forwarded.
- Credit counters: one per output, reset to CREDITS.
  - Grant only: −1. in_credit only: +1. Both in the same cycle: unchanged.
  - in_credit while the counter is at CREDITS (with no grant) is ignored; the counter saturates.
  - The counter never underflows, because a grant requires count>0.
- Switch allocation: per output o, an independent round-robin arbiter.
  - Requesters are inputs with a non-empty FIFO, head target o, and credit[o]>0.
  - The search starts at pointer rr[o] and proceeds in ascending index order with wrap-around.
  - On a grant to input i, rr[o] becomes (i+1) mod NUM_PORTS; with no grant, rr[o] holds.
  - Each input requests at most one output, so no input-side conflict exists.
  - A granted input pops its head in the same cycle.
  - Loopback (input p targeting output p) is allowed.
- Stage 3: out_data[o] is loaded with the granted flit, unmodified including the target field, and out_valid[o]=1.
  - With no grant, out_valid[o]=0 and out_data[o] holds its last value.
- out_credit[p] is registered: it pulses in the cycle after the pop (granted or discarded), aligned with the corresponding out_valid.
- ovf and bad_tgt clear only on reset.

## Timing
- Reset (asynchronous, rst=0) state:
  - All FIFOs empty.
  - Credit counters = CREDITS; rr pointers = 0.
  - out_data=0, out_valid=0, out_credit=0, ovf=0, bad_tgt=0.
  - Internal pipeline registers = 0.
- Reset mid-operation flushes all in-flight flits; no credits are returned for them.
- Latency: a flit driven with in_valid in cycle 0 reaches the FIFO head in cycle 2. If uncontended with credit available, out_valid is asserted in cycle 3 and out_credit in cycle 3.
- Throughput: 1 flit/cycle per input and per output when credits permit.
- A blocked head (no credit or arbitration loss) causes no pop; the next flit waits behind it (head-of-line blocking).
- A credit arriving via in_credit in cycle n enables a grant in cycle n+1 at the earliest.
- Upstream compliance: upstream sends at most FIFO_DEPTH flits beyond returned credits; ovf flags violations only.

## Test plan
- Single flit: input 0 sends 0x00012 (target 2) in cycle 0 -> out_valid[1]=1 with out_data[1]=0x00012 in cycle 3, out_credit[0]=1 in cycle 3, all other outputs 0.
- Contention: inputs 0, 2, 4 each send one flit with target 3 in the same cycle; in_credit[2] is pulsed every cycle -> output 2 emits input 0, input 2, input 4 flits on consecutive cycles; rr[2] ends at 0.
- Credit exhaustion: CREDITS=4, input 1 streams 6 flits to target 1 with no in_credit -> exactly 4 flits on output 0, then stall. A single in_credit pulse releases flit 5 one cycle later; flit 6 remains buffered.
- Simultaneous grant and credit return at credit count 1 -> count stays 1; no spurious stall.
- Illegal target: input 3 sends target 0, then target 7 (NUM_PORTS=5) -> no out_valid, two out_credit[3] pulses, bad_tgt[3]=1.
- Overflow and reset: 6 back-to-back flits into input 4 with output 4 blocked -> ovf[4]=1 and 4 flits held. Asserting rst mid-stream clears all outputs to 0 and credit counters to CREDITS immediately.

Source files
------------

// File: rtl/noc_router_param.sv
`default_nettype none
// ============================================================================
//  Module   : noc_router_param
//  Purpose  : Parametrised credit-flow-controlled NoC router. It has three
//             stages: an input register, per-input FIFOs with per-output
//             round-robin switch allocation, and a registered crossbar output.
//             Lookahead target (1-based) sits in flit[TGT_W-1:0].
//  Revision : 1.0  initial release
// ============================================================================
module noc_router_param #(
   parameter int NUM_PORTS  = 5,
   parameter int DATA_W     = 20,
   parameter int FIFO_DEPTH = 4,
   parameter int CREDITS    = 4,
   parameter int TGT_W      = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   input  logic [NUM_PORTS-1:0]        in_valid,
   input  logic [NUM_PORTS-1:0]        in_credit,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS-1:0]        out_valid,
   output logic [NUM_PORTS-1:0]        out_credit,
   output logic [NUM_PORTS-1:0]        ovf,
   output logic [NUM_PORTS-1:0]        bad_tgt
);

   localparam int               c_aw        = $clog2(FIFO_DEPTH);
   localparam int               c_pw        = $clog2(NUM_PORTS);
   localparam int               c_cw        = $clog2(CREDITS + 1);
   localparam logic [c_aw:0]    c_fifo_full = (c_aw + 1)'(FIFO_DEPTH);
   localparam logic [c_cw-1:0]  c_cred_max  = c_cw'(CREDITS);
   localparam logic [TGT_W-1:0] c_max_tgt   = TGT_W'(NUM_PORTS);
   localparam logic [c_pw-1:0]  c_last_port = c_pw'(NUM_PORTS - 1);

   logic [NUM_PORTS-1:0][DATA_W-1:0]    r_in_d;
   logic [NUM_PORTS-1:0]                r_in_v;
   logic [NUM_PORTS-1:0][DATA_W-1:0]    w_head;
   logic [NUM_PORTS-1:0]                w_empty;
   logic [NUM_PORTS-1:0]                w_full;
   logic [NUM_PORTS-1:0]                w_legal;
   logic [NUM_PORTS-1:0]                w_bad;
   logic [NUM_PORTS-1:0]                w_pop;
   logic [NUM_PORTS-1:0]                w_ovf_evt;
   // request / grant matrices are indexed [output][input]
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;
   logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_gnt;
   logic [NUM_PORTS-1:0]                w_gnt_v;
   logic [NUM_PORTS-1:0][c_pw-1:0]      w_gnt_idx;
   logic [NUM_PORTS-1:0][c_pw-1:0]      r_rr;
   logic [NUM_PORTS-1:0][c_cw-1:0]      r_cred;
   logic [NUM_PORTS-1:0][DATA_W-1:0]    r_out_d;
   logic [NUM_PORTS-1:0]                r_out_v;
   logic [NUM_PORTS-1:0]                r_out_cr;
   logic [NUM_PORTS-1:0]                r_ovf;
   logic [NUM_PORTS-1:0]                r_bad;

   // Stage 1: register incoming flits unconditionally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_d <= '0;
         r_in_v <= '0;
      end else begin
         r_in_d <= in_data;
         r_in_v <= in_valid;
      end
   end

   // Stage 2: one circular FIFO per input; a full FIFO still accepts a push
   // when its head is leaving in the same cycle
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_fifo
      logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
      logic [c_aw-1:0]   r_wp;
      logic [c_aw-1:0]   r_rp;
      logic [c_aw:0]     r_cnt;
      logic              w_push;

      assign w_empty[p]   = (r_cnt == '0);
      assign w_full[p]    = (r_cnt == c_fifo_full);
      assign w_push       = r_in_v[p] && (!w_full[p] || w_pop[p]);
      assign w_ovf_evt[p] = r_in_v[p] && w_full[p] && !w_pop[p];
      assign w_head[p]    = r_mem[r_rp];

      // Flit storage; contents are qualified by the occupancy count
      always_ff @(posedge clk) begin
         if (w_push) begin
            r_mem[r_wp] <= r_in_d[p];
         end
      end

      // Read/write pointers and occupancy
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_push)   r_wp <= r_wp + 1'b1;
            if (w_pop[p]) r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop[p]})
               2'b10:   r_cnt <= r_cnt + 1'b1;
               2'b01:   r_cnt <= r_cnt - 1'b1;
               default: r_cnt <= r_cnt;
            endcase
         end
      end
   end

   // Head target decode: legal targets raise a request only when credit exists
   always_comb begin
      w_legal = '0;
      w_bad   = '0;
      w_req   = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_legal[p] = (w_head[p][TGT_W-1:0] != '0) &&
                      (w_head[p][TGT_W-1:0] <= c_max_tgt);
         w_bad[p]   = !w_empty[p] && !w_legal[p];
         for (int o = 0; o < NUM_PORTS; o++) begin
            w_req[o][p] = !w_empty[p] && w_legal[p] &&
                          (w_head[p][TGT_W-1:0] == TGT_W'(o + 1)) &&
                          (r_cred[o] != '0);
         end
      end
   end

   // Per-output round-robin search from rr[o]; illegal heads pop without a grant
   always_comb begin
      int j;
      j         = 0;
      w_gnt     = '0;
      w_gnt_v   = '0;
      w_gnt_idx = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(r_rr[o]) + k;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (!w_gnt_v[o] && w_req[o][j]) begin
               w_gnt_v[o]   = 1'b1;
               w_gnt[o][j]  = 1'b1;
               w_gnt_idx[o] = c_pw'(j);
            end
         end
      end
      w_pop = w_bad;
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_pop = w_pop | w_gnt[o];
      end
   end

   // Stage 3 crossbar register, arbiter pointers, credit counters, sticky flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cred   <= {NUM_PORTS{c_cred_max}};
         r_rr     <= '0;
         r_out_d  <= '0;
         r_out_v  <= '0;
         r_out_cr <= '0;
         r_ovf    <= '0;
         r_bad    <= '0;
      end else begin
         r_out_v  <= w_gnt_v;
         r_out_cr <= w_pop;
         r_ovf    <= r_ovf | w_ovf_evt;
         r_bad    <= r_bad | w_bad;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_gnt_v[o]) begin
               r_out_d[o] <= w_head[w_gnt_idx[o]];
               r_rr[o]    <= (w_gnt_idx[o] == c_last_port) ? '0 : w_gnt_idx[o] + 1'b1;
            end
            // a grant and a returned credit in the same cycle cancel out
            case ({w_gnt_v[o], in_credit[o]})
               2'b10: r_cred[o] <= r_cred[o] - 1'b1;
               2'b01: if (r_cred[o] != c_cred_max) r_cred[o] <= r_cred[o] + 1'b1;
               default: r_cred[o] <= r_cred[o];
            endcase
         end
      end
   end

   assign out_data   = r_out_d;
   assign out_valid  = r_out_v;
   assign out_credit = r_out_cr;
   assign ovf        = r_ovf;
   assign bad_tgt    = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_noc_router_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_router_param
//  Purpose  : Directed self-checking bench for noc_router_param (defaults).
//  Revision : 1.0  initial release
// ============================================================================
module tb_noc_router_param;

   localparam int NUM_PORTS = 5;
   localparam int DATA_W    = 20;

   logic                        clk;
   logic                        rst;
   logic [NUM_PORTS*DATA_W-1:0] in_data;
   logic [NUM_PORTS-1:0]        in_valid;
   logic [NUM_PORTS-1:0]        in_credit;
   logic [NUM_PORTS*DATA_W-1:0] out_data;
   logic [NUM_PORTS-1:0]        out_valid;
   logic [NUM_PORTS-1:0]        out_credit;
   logic [NUM_PORTS-1:0]        ovf;
   logic [NUM_PORTS-1:0]        bad_tgt;

   int n_checks = 0;
   int n_fail   = 0;

   noc_router_param #(
      .NUM_PORTS  (NUM_PORTS),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (4),
      .CREDITS    (4),
      .TGT_W      (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_credit  (in_credit),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_credit (out_credit),
      .ovf        (ovf),
      .bad_tgt    (bad_tgt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int p, input logic [DATA_W-1:0] d);
      in_data[p*DATA_W +: DATA_W] = d;
      in_valid[p] = 1'b1;
   endtask

   task automatic idle();
      in_data  = '0;
      in_valid = '0;
   endtask

   function automatic logic [DATA_W-1:0] out_d(input int o);
      return out_data[o*DATA_W +: DATA_W];
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      in_credit = '0;
      step();
      step();
      // ---------------- reset state
      check("rst_out_valid",  out_valid,  5'b0);
      check("rst_out_credit", out_credit, 5'b0);
      check("rst_ovf",        ovf,        5'b0);
      check("rst_bad_tgt",    bad_tgt,    5'b0);
      check("rst_out_data",   out_data[31:0], 32'h0);
      rst = 1'b1;
      step();

      // ---------------- single flit: input 0, target 2 -> output 1 at cycle 3
      send(0, 20'h00012);
      step(); idle();
      step();
      check("t1_c2_valid", out_valid, 5'b0);
      step();
      check("t1_valid",  out_valid,  5'b00010);
      check("t1_data",   out_d(1),   20'h00012);
      check("t1_credit", out_credit, 5'b00001);
      step();
      check("t1_after", out_valid, 5'b0);

      // ---------------- contention on output 2 from inputs 0, 2, 4
      send(0, 20'hA0003);
      send(2, 20'hB0003);
      send(4, 20'hC0003);
      in_credit = 5'b00100;
      step(); idle();
      step();
      step();
      check("t2_c3_valid",  out_valid,  5'b00100);
      check("t2_c3_data",   out_d(2),   20'hA0003);
      check("t2_c3_credit", out_credit, 5'b00001);
      step();
      check("t2_c4_valid",  out_valid,  5'b00100);
      check("t2_c4_data",   out_d(2),   20'hB0003);
      check("t2_c4_credit", out_credit, 5'b00100);
      step();
      in_credit = '0;
      check("t2_c5_valid",  out_valid,  5'b00100);
      check("t2_c5_data",   out_d(2),   20'hC0003);
      check("t2_c5_credit", out_credit, 5'b10000);
      step();
      check("t2_c6_valid", out_valid, 5'b0);
      // rr[2] wrapped to 0: input 0 must beat input 1
      send(0, 20'h11003);
      send(1, 20'h22003);
      step(); idle();
      step();
      step();
      check("t2_rr_first",  out_d(2), 20'h11003);
      step();
      check("t2_rr_second", out_d(2), 20'h22003);
      step();

      // ---------------- credit exhaustion: input 1 streams 6 flits to output 0
      for (int c = 0; c < 9; c++) begin
         if (c < 6) send(1, 20'((c + 1) << 16) | 20'h00001);
         else idle();
         if (c >= 3) begin
            if (c <= 6) begin
               check("t3_valid",  out_valid,  5'b00001);
               check("t3_data",   out_d(0),   20'((c - 2) << 16) | 20'h00001);
               check("t3_credit", out_credit, 5'b00010);
            end else begin
               check("t3_stall", out_valid, 5'b0);
            end
         end
         step();
      end
      in_credit = 5'b00001;
      check("t3_c9_valid", out_valid, 5'b0);
      step();
      in_credit = '0;
      check("t3_c10_valid", out_valid, 5'b0);
      step();
      check("t3_rel_valid",  out_valid,  5'b00001);
      check("t3_rel_data",   out_d(0),   20'h50001);
      check("t3_rel_credit", out_credit, 5'b00010);
      step();
      check("t3_hold6", out_valid, 5'b0);

      // ---------------- grant and credit return together at count 1
      step();
      in_credit = 5'b00001;
      send(1, 20'h70001);
      step();
      idle();
      check("t4_c14_valid", out_valid, 5'b0);
      step();
      in_credit = '0;
      check("t4_f6_valid", out_valid, 5'b00001);
      check("t4_f6_data",  out_d(0),  20'h60001);
      step();
      check("t4_f7_valid", out_valid, 5'b00001);
      check("t4_f7_data",  out_d(0),  20'h70001);
      step();
      check("t4_after", out_valid, 5'b0);

      // ---------------- illegal targets on input 3
      send(3, 20'h00030);
      step();
      send(3, 20'h00037);
      step(); idle();
      check("t5_c2_credit", out_credit, 5'b0);
      step();
      check("t5_c3_credit", out_credit, 5'b01000);
      check("t5_c3_valid",  out_valid,  5'b0);
      step();
      check("t5_c4_credit", out_credit, 5'b01000);
      check("t5_c4_valid",  out_valid,  5'b0);
      check("t5_bad_tgt",   bad_tgt,    5'b01000);
      step();
      check("t5_c5_credit", out_credit, 5'b0);

      // ---------------- overflow on input 4 with output 4 out of credit
      for (int c = 0; c < 4; c++) begin
         send(0, 20'h00105);
         step();
      end
      idle();
      repeat (6) step();
      for (int c = 0; c < 6; c++) begin
         send(4, 20'hD0005);
         step();
      end
      idle();
      step();
      check("t6_ovf",     ovf,       5'b10000);
      check("t6_valid",   out_valid, 5'b0);
      check("t6_bad_tgt", bad_tgt,   5'b01000);
      // asynchronous reset in the middle of a stream
      send(4, 20'hD0005);
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_valid",  out_valid,  5'b0);
      check("t6_rst_ovf",    ovf,        5'b0);
      check("t6_rst_bad",    bad_tgt,    5'b0);
      check("t6_rst_credit", out_credit, 5'b0);
      check("t6_rst_data4",  out_d(4),   20'h0);
      check("t6_rst_data0",  out_d(0),   20'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      // flushed FIFOs with restored credits must stay silent
      for (int c = 0; c < 5; c++) begin
         step();
         check("t6_flushed", out_valid, 5'b0);
      end
      // restored credits let a fresh flit through to output 4
      send(0, 20'hE0005);
      step(); idle();
      step();
      step();
      check("t6_new_valid", out_valid, 5'b10000);
      check("t6_new_data",  out_d(4),  20'hE0005);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
